seg_ctrl_param: RTL and testbench
=================================

SEG_CTRL_PARAM -- requirements
Module: seg_ctrl_param

Interface
- REQ-001 SHALL have parameter K_W, default 16: width of block size K and filler count F.
- REQ-002 SHALL have parameter C_W, default 8: width of the per-descriptor block counts C+ and C-.
- REQ-003 SHALL have parameter CRC_LEN, default 24: per-block CRC length in bits, minimum 1.
- REQ-004 SHALL have port clk, input, 1: the single clock, all logic on its rising edge.
- REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
- REQ-006 SHALL have port empty_size_fifo, input, 1: descriptor FIFO empty.
- REQ-007 SHALL have port empty_data_fifo, input, 1: data FIFO (show-ahead) empty.
- REQ-008 SHALL have ports desc_f (K_W), desc_cm (C_W), desc_cp (C_W), desc_km (K_W) and desc_kp (K_W), inputs: descriptor fields F, C-, C+, K- and K+.
- REQ-009 SHALL have ports read_size_fifo and read_data_fifo, outputs, 1: FIFO pop strobes.
- REQ-010 SHALL have ports mux_fill, mux_crc, init_crc, ena_crc and nshift_crc, outputs, 1: datapath and CRC-engine controls.
- REQ-011 SHALL have ports start, filling, stop, crc, block_size, busy, stall and desc_err, outputs, 1: framing and status flags.

Function
- REQ-012 SHALL implement states IDLE, READ_REQ, READ_DESC, LOAD_BLK, FILLING, READ_DATA, OUT_CRC and NEXT_BLOCK; any other encoding SHALL go to IDLE.
- REQ-013 Output defaults, unless a state requirement below overrides them:
  - mux_fill=1, nshift_crc=1;
  - all other outputs 0;
  - busy=1 in every state except IDLE.
- REQ-014 IDLE:
  - init_crc=1, ena_crc=1;
  - goes to READ_REQ when empty_size_fifo=0.
- REQ-015 READ_REQ: read_size_fifo=1 for exactly one cycle, then READ_DESC.
- REQ-016 READ_DESC:
  - registers all desc_* fields, read one cycle after the pop;
  - sets crc_req=1 if C-+C+>1, else 0.
- REQ-017 READ_DESC error check: if C-+C+=0, or any nonzero-count K is <= F+CRC_LEN*crc_req, then desc_err SHALL pulse 1 cycle and the state SHALL return to IDLE.
- REQ-018 READ_DESC otherwise goes to LOAD_BLK.
- REQ-019 Block order: all K- blocks SHALL be emitted before any K+ block.
- REQ-020 LOAD_BLK (single cycle) sets start=1, init_crc=1 and ena_crc=1.
- REQ-021 LOAD_BLK selects K = K- if cm_rem>0, else K+; block_size = 1 when K+ is selected.
- REQ-022 LOAD_BLK decrements the selected remaining count by 1.
- REQ-023 LOAD_BLK loads data_cnt = K - fill_rem - CRC_LEN*crc_req; all arithmetic is K_W-bit unsigned, and REQ-017 guarantees it cannot underflow.
- REQ-024 LOAD_BLK goes to FILLING if fill_rem>0, else READ_DATA.
- REQ-025 Filler: fill_rem = F for the first block only and SHALL be cleared to 0 after that block's FILLING completes.
- REQ-026 FILLING emits one filler bit per cycle with mux_fill=0 and filling=1, for exactly F cycles, then READ_DATA.
- REQ-027 READ_DATA with empty_data_fifo=0:
  - read_data_fifo=1, ena_crc=1, data_cnt decrements;
  - on the read with data_cnt=1, goes to OUT_CRC if crc_req=1, else NEXT_BLOCK.
- REQ-028 READ_DATA with empty_data_fifo=1:
  - stall=1;
  - read_data_fifo=0 and ena_crc=0;
  - all counters hold and the state holds.
- REQ-029 OUT_CRC:
  - mux_crc=1, crc=1, nshift_crc=0, ena_crc=1;
  - lasts exactly CRC_LEN cycles, independent of empty_data_fifo, then NEXT_BLOCK.
- REQ-030 NEXT_BLOCK:
  - stop=1 for one cycle;
  - goes to IDLE if cm_rem=0 and cp_rem=0, else LOAD_BLK.
- REQ-031 Each block SHALL produce exactly K output-bit cycles across FILLING+READ_DATA+OUT_CRC, excluding stall cycles.
- REQ-032 Counts up to 2^C_W-1 blocks per type SHALL be supported with no wrap.
- REQ-033 desc_* inputs outside the READ_DESC capture cycle SHALL be ignored.

Reset
- REQ-034 While reset=1 at a clock edge:
  - state -> IDLE;
  - all counters and registered descriptor fields -> 0;
  - crc_req -> 0.
- REQ-035 After reset, outputs SHALL be the IDLE values: init_crc=1, ena_crc=1, mux_fill=1, nshift_crc=1, all others 0.
- REQ-036 Reset mid-block SHALL abandon the block with no stop pulse.
- REQ-037 A new descriptor SHALL be processed normally after reset deasserts.

Verification
- REQ-038 Single block: C-=0, C+=1, K+=40, F=0 -> one start, 40 consecutive read_data_fifo, crc never 1, stop, then IDLE.
- REQ-039 Two blocks: C-=1, C+=1, K-=40, K+=48, F=8, CRC_LEN=24 ->
  - block 0: block_size=0, 8 filling, 8 reads, 24 crc;
  - block 1: block_size=1, 0 filling, 24 reads, 24 crc;
  - 2 start and 2 stop pulses;
  - init_crc=1 in each LOAD_BLK.
- REQ-040 Stall: hold empty_data_fifo=1 for 3 cycles during READ_DATA -> stall=1 for 3 cycles, no reads, data_cnt unchanged, total reads still equal to data_cnt.
- REQ-041 Bad descriptor: C+=2, K+=24, F=0 -> desc_err one pulse, no start, back in IDLE within 1 cycle.
- REQ-042 Reset in OUT_CRC at bit 10 -> next cycle in IDLE with IDLE outputs, no stop; the following descriptor completes correctly.
- REQ-043 Back-to-back: two queued descriptors -> the second read_size_fifo occurs exactly 2 cycles after the first descriptor's final stop.

Source files
------------

// File: rtl/seg_ctrl_param.sv
// Segmentation controller: one descriptor (F, C-, C+, K-, K+) becomes a
// sequence of code blocks. The first block carries F filler bits. Every
// block then reads its payload from a show-ahead data FIFO. A per-block CRC
// is appended when the descriptor yields more than one block.
module seg_ctrl_param #(
  parameter int K_W     = 16,
  parameter int C_W     = 8,
  parameter int CRC_LEN = 24
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           empty_size_fifo,
  input  logic           empty_data_fifo,
  input  logic [K_W-1:0] desc_f,
  input  logic [C_W-1:0] desc_cm,
  input  logic [C_W-1:0] desc_cp,
  input  logic [K_W-1:0] desc_km,
  input  logic [K_W-1:0] desc_kp,
  output logic           read_size_fifo,
  output logic           read_data_fifo,
  output logic           mux_fill,
  output logic           mux_crc,
  output logic           init_crc,
  output logic           ena_crc,
  output logic           nshift_crc,
  output logic           start,
  output logic           filling,
  output logic           stop,
  output logic           crc,
  output logic           block_size,
  output logic           busy,
  output logic           stall,
  output logic           desc_err
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    READ_REQ   = 3'd1,
    READ_DESC  = 3'd2,
    LOAD_BLK   = 3'd3,
    FILLING    = 3'd4,
    READ_DATA  = 3'd5,
    OUT_CRC    = 3'd6,
    NEXT_BLOCK = 3'd7
  } state_t;

  localparam int               CNT_W    = (CRC_LEN > 1) ? $clog2(CRC_LEN) : 1;
  localparam logic [CNT_W-1:0] CRC_LAST = CNT_W'(CRC_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [K_W-1:0]   CRC_K    = K_W'(CRC_LEN);
  localparam logic [K_W-1:0]   K_ONE    = K_W'(1);
  localparam logic [C_W-1:0]   C_ONE    = C_W'(1);
  localparam logic [C_W:0]     SUM_ONE  = (C_W + 1)'(1);

  state_t           state_q, state_d;
  logic [K_W-1:0]   km_q, km_d;
  logic [K_W-1:0]   kp_q, kp_d;
  logic [C_W-1:0]   cm_rem_q, cm_rem_d;
  logic [C_W-1:0]   cp_rem_q, cp_rem_d;
  logic [K_W-1:0]   fill_rem_q, fill_rem_d;
  logic [K_W-1:0]   data_cnt_q, data_cnt_d;
  logic [CNT_W-1:0] crc_cnt_q, crc_cnt_d;
  logic             crc_req_q, crc_req_d;

  // Descriptor validation terms, evaluated on the live FIFO outputs.
  // They are one bit wider so F + CRC_LEN cannot wrap.
  logic [C_W:0]   desc_sum;
  logic           desc_crc;
  logic [K_W:0]   desc_thresh;
  logic           desc_bad;
  logic [K_W-1:0] k_sel;
  logic [K_W-1:0] crc_term;

  // Descriptor sanity check and per-block size selection.
  always_comb begin
    desc_sum    = {1'b0, desc_cm} + {1'b0, desc_cp};
    desc_crc    = (desc_sum > SUM_ONE);
    desc_thresh = {1'b0, desc_f} + (desc_crc ? {1'b0, CRC_K} : '0);
    desc_bad    = (desc_sum == '0)
               || ((desc_cm != '0) && ({1'b0, desc_km} <= desc_thresh))
               || ((desc_cp != '0) && ({1'b0, desc_kp} <= desc_thresh));
    k_sel       = (cm_rem_q != '0) ? km_q : kp_q;
    crc_term    = crc_req_q ? CRC_K : '0;
  end

  // Next-state, counter updates and all control outputs.
  always_comb begin
    state_d        = state_q;
    km_d           = km_q;
    kp_d           = kp_q;
    cm_rem_d       = cm_rem_q;
    cp_rem_d       = cp_rem_q;
    fill_rem_d     = fill_rem_q;
    data_cnt_d     = data_cnt_q;
    crc_cnt_d      = crc_cnt_q;
    crc_req_d      = crc_req_q;
    read_size_fifo = 1'b0;
    read_data_fifo = 1'b0;
    mux_fill       = 1'b1;
    mux_crc        = 1'b0;
    init_crc       = 1'b0;
    ena_crc        = 1'b0;
    nshift_crc     = 1'b1;
    start          = 1'b0;
    filling        = 1'b0;
    stop           = 1'b0;
    crc            = 1'b0;
    block_size     = 1'b0;
    busy           = (state_q != IDLE);
    stall          = 1'b0;
    desc_err       = 1'b0;
    case (state_q)
      IDLE: begin
        init_crc = 1'b1;
        ena_crc  = 1'b1;
        if (!empty_size_fifo) state_d = READ_REQ;
      end
      READ_REQ: begin
        read_size_fifo = 1'b1;
        state_d        = READ_DESC;
      end
      READ_DESC: begin
        // The FIFO shows the popped descriptor one cycle after the pop.
        km_d       = desc_km;
        kp_d       = desc_kp;
        cm_rem_d   = desc_cm;
        cp_rem_d   = desc_cp;
        fill_rem_d = desc_f;
        crc_req_d  = desc_crc;
        if (desc_bad) begin
          desc_err = 1'b1;
          state_d  = IDLE;
        end else begin
          state_d  = LOAD_BLK;
        end
      end
      LOAD_BLK: begin
        start    = 1'b1;
        init_crc = 1'b1;
        ena_crc  = 1'b1;
        // All K- blocks go out before any K+ block.
        if (cm_rem_q != '0) begin
          cm_rem_d = cm_rem_q - C_ONE;
        end else begin
          cp_rem_d   = cp_rem_q - C_ONE;
          block_size = 1'b1;
        end
        data_cnt_d = k_sel - fill_rem_q - crc_term;
        crc_cnt_d  = '0;
        state_d    = (fill_rem_q != '0) ? FILLING : READ_DATA;
      end
      FILLING: begin
        // Counting fill_rem down to zero also leaves later blocks unfilled.
        mux_fill   = 1'b0;
        filling    = 1'b1;
        fill_rem_d = fill_rem_q - K_ONE;
        if (fill_rem_q == K_ONE) state_d = READ_DATA;
      end
      READ_DATA: begin
        if (empty_data_fifo) begin
          stall = 1'b1;
        end else begin
          read_data_fifo = 1'b1;
          ena_crc        = 1'b1;
          data_cnt_d     = data_cnt_q - K_ONE;
          if (data_cnt_q == K_ONE) state_d = crc_req_q ? OUT_CRC : NEXT_BLOCK;
        end
      end
      OUT_CRC: begin
        mux_crc    = 1'b1;
        crc        = 1'b1;
        nshift_crc = 1'b0;
        ena_crc    = 1'b1;
        crc_cnt_d  = crc_cnt_q + CNT_ONE;
        if (crc_cnt_q == CRC_LAST) state_d = NEXT_BLOCK;
      end
      NEXT_BLOCK: begin
        stop    = 1'b1;
        state_d = ((cm_rem_q == '0) && (cp_rem_q == '0)) ? IDLE : LOAD_BLK;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      km_q       <= '0;
      kp_q       <= '0;
      cm_rem_q   <= '0;
      cp_rem_q   <= '0;
      fill_rem_q <= '0;
      data_cnt_q <= '0;
      crc_cnt_q  <= '0;
      crc_req_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      km_q       <= km_d;
      kp_q       <= kp_d;
      cm_rem_q   <= cm_rem_d;
      cp_rem_q   <= cp_rem_d;
      fill_rem_q <= fill_rem_d;
      data_cnt_q <= data_cnt_d;
      crc_cnt_q  <= crc_cnt_d;
      crc_req_q  <= crc_req_d;
    end
  end

endmodule

// File: tb/tb_seg_ctrl_param.sv
// Scoreboard bench for seg_ctrl_param. Stimulus queues descriptors into a
// FIFO model and pushes the block summaries it expects. A negedge monitor
// builds one summary per block and pops and compares one expectation at
// every stop or desc_err.
module tb_seg_ctrl_param;
  localparam int K_W     = 16;
  localparam int C_W     = 8;
  localparam int CRC_LEN = 24;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           empty_size_fifo = 1'b1;
  logic           empty_data_fifo = 1'b0;
  logic [K_W-1:0] desc_f = '0;
  logic [C_W-1:0] desc_cm = '0;
  logic [C_W-1:0] desc_cp = '0;
  logic [K_W-1:0] desc_km = '0;
  logic [K_W-1:0] desc_kp = '0;
  logic read_size_fifo, read_data_fifo, mux_fill, mux_crc, init_crc, ena_crc;
  logic nshift_crc, start, filling, stop, crc, block_size, busy, stall, desc_err;

  always #5 clk = ~clk;

  seg_ctrl_param #(.K_W(K_W), .C_W(C_W), .CRC_LEN(CRC_LEN)) dut (
    .clk(clk), .reset(reset),
    .empty_size_fifo(empty_size_fifo), .empty_data_fifo(empty_data_fifo),
    .desc_f(desc_f), .desc_cm(desc_cm), .desc_cp(desc_cp),
    .desc_km(desc_km), .desc_kp(desc_kp),
    .read_size_fifo(read_size_fifo), .read_data_fifo(read_data_fifo),
    .mux_fill(mux_fill), .mux_crc(mux_crc), .init_crc(init_crc),
    .ena_crc(ena_crc), .nshift_crc(nshift_crc), .start(start),
    .filling(filling), .stop(stop), .crc(crc), .block_size(block_size),
    .busy(busy), .stall(stall), .desc_err(desc_err)
  );

  logic [14:0] ov;
  assign ov = {read_size_fifo, read_data_fifo, mux_fill, mux_crc, init_crc,
               ena_crc, nshift_crc, start, filling, stop, crc, block_size,
               busy, stall, desc_err};
  localparam logic [14:0] IDLE_OV = 15'h1700;

  typedef struct {
    logic [K_W-1:0] f;
    logic [C_W-1:0] cm;
    logic [C_W-1:0] cp;
    logic [K_W-1:0] km;
    logic [K_W-1:0] kp;
  } desc_t;
  typedef struct {
    int kind;   // 0 = block, 1 = descriptor error
    int bs;
    int fill;
    int reads;
    int crcs;
    int stalls;
  } exp_t;

  desc_t dq[$];
  exp_t  exp_q[$];
  int    n_vec = 0;
  int    n_bad = 0;
  int    cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int got, input int expv);
    n_vec++;
    if (got !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)", name, got, expv, cyc);
    end
  endtask

  // Descriptor FIFO model: data appears after the pop and holds through the
  // capture cycle. At all other times the fields carry random junk.
  bit    hold = 1'b0;
  desc_t cur;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (read_size_fifo && dq.size() > 0) begin
        cur     = dq.pop_front();
        desc_f  = cur.f;
        desc_cm = cur.cm;
        desc_cp = cur.cp;
        desc_km = cur.km;
        desc_kp = cur.kp;
        hold    = 1'b1;
      end else if (hold) begin
        hold = 1'b0;
      end else begin
        desc_f  = K_W'($urandom);
        desc_cm = C_W'($urandom);
        desc_cp = C_W'($urandom);
        desc_km = K_W'($urandom);
        desc_kp = K_W'($urandom);
      end
      empty_size_fifo = (dq.size() == 0);
    end
  end

  // Monitor: per-block summaries and scoreboard comparison.
  bit in_blk = 1'b0;
  int m_bs, m_fill, m_reads, m_crc, m_stalls, m_viol;
  int mon_stops = 0;
  int n_blk = 0;
  int stop_cyc[$];
  int rs_cyc[$];
  exp_t e;
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        in_blk = 1'b0;
      end else begin
        if (read_size_fifo) rs_cyc.push_back(cyc);
        if (start) begin
          if (exp_q.size() > 0) chk("start_kind", 0, exp_q[0].kind);
          in_blk   = 1'b1;
          m_bs     = int'(block_size);
          m_fill   = 0;
          m_reads  = 0;
          m_crc    = 0;
          m_stalls = 0;
          m_viol   = (init_crc && ena_crc) ? 0 : 1;
        end
        if (in_blk) begin
          if (filling) m_fill++;
          if (read_data_fifo) m_reads++;
          if (crc) m_crc++;
          if (stall && !read_data_fifo) m_stalls++;
          if (filling && mux_fill) m_viol++;
          if (crc && (!mux_crc || nshift_crc || !ena_crc)) m_viol++;
          if (read_data_fifo && !ena_crc) m_viol++;
          if (stall && (read_data_fifo || ena_crc)) m_viol++;
        end
        if (stop) begin
          mon_stops++;
          stop_cyc.push_back(cyc);
          $display("blk %0d: bs=%0d fill=%0d reads=%0d crc=%0d stalls=%0d",
                   n_blk, m_bs, m_fill, m_reads, m_crc, m_stalls);
          n_blk++;
          if (exp_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL stop_unexpected: got stop with no block pending (cycle %0d)", cyc);
          end else begin
            e = exp_q.pop_front();
            chk("blk_kind", 0, e.kind);
            chk("blk_size", m_bs, e.bs);
            chk("blk_fill", m_fill, e.fill);
            chk("blk_reads", m_reads, e.reads);
            chk("blk_crc", m_crc, e.crcs);
            chk("blk_stalls", m_stalls, e.stalls);
            chk("blk_ctrl_viol", m_viol, 0);
          end
          in_blk = 1'b0;
        end
        if (desc_err) begin
          $display("desc_err at cycle %0d", cyc);
          if (exp_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL err_unexpected: got desc_err with nothing pending (cycle %0d)", cyc);
          end else begin
            e = exp_q.pop_front();
            chk("err_kind", 1, e.kind);
          end
        end
      end
    end
  end

  task automatic push_desc(input int f, input int cm, input int cp, input int km, input int kp);
    desc_t d;
    d.f  = K_W'(f);
    d.cm = C_W'(cm);
    d.cp = C_W'(cp);
    d.km = K_W'(km);
    d.kp = K_W'(kp);
    dq.push_back(d);
  endtask

  task automatic push_blk(input int bs, input int fill, input int reads, input int crcs, input int stalls);
    exp_t x;
    x.kind = 0; x.bs = bs; x.fill = fill; x.reads = reads; x.crcs = crcs; x.stalls = stalls;
    exp_q.push_back(x);
  endtask

  task automatic push_err();
    exp_t x;
    x.kind = 1; x.bs = 0; x.fill = 0; x.reads = 0; x.crcs = 0; x.stalls = 0;
    exp_q.push_back(x);
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (n < budget &&
               !(exp_q.size() == 0 && dq.size() == 0 && !busy && empty_size_fifo));
    if (n >= budget) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s_timeout: pending=%0d busy=%0d after %0d cycles", name, exp_q.size(), busy, n);
    end
  endtask

  task automatic wait_cond_reads(input int target);
    int n = 0;
    while (n < 500 && !(in_blk && m_reads >= target)) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 500) begin
      n_vec++;
      n_bad++;
      $display("FAIL wait_reads_timeout: reads=%0d required %0d", m_reads, target);
    end
  endtask

  task automatic wait_cond_crc(input int target);
    int n = 0;
    while (n < 500 && !(in_blk && m_crc >= target)) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 500) begin
      n_vec++;
      n_bad++;
      $display("FAIL wait_crc_timeout: crc=%0d required %0d", m_crc, target);
    end
  endtask

  int s_stops;

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_outputs", int'(ov), int'(IDLE_OV));

    // Single block, no CRC: 40 reads.
    push_desc(0, 0, 1, 0, 40);
    push_blk(1, 0, 40, 0, 0);
    wait_done("single", 400);

    // Two blocks with filler on the first: 8 fill + 8 reads + 24 crc, then 24 + 24.
    push_desc(8, 1, 1, 40, 48);
    push_blk(0, 8, 8, 24, 0);
    push_blk(1, 0, 24, 24, 0);
    wait_done("two_blk", 600);

    // Three blocks, F=3: K-=30 -> 3 reads, 6 reads; K+=28 -> 4 reads.
    push_desc(3, 2, 1, 30, 28);
    push_blk(0, 3, 3, 24, 0);
    push_blk(0, 0, 6, 24, 0);
    push_blk(1, 0, 4, 24, 0);
    wait_done("three_blk", 800);

    // Lone K- block, no CRC. K+ is ignored because C+=0.
    push_desc(2, 1, 0, 10, 0);
    push_blk(0, 2, 8, 0, 0);
    wait_done("lone_km", 300);

    // Stall of 3 cycles after 10 reads; the total stays at 30.
    push_desc(0, 0, 1, 0, 30);
    push_blk(1, 0, 30, 0, 3);
    wait_cond_reads(10);
    empty_data_fifo = 1'b1;
    repeat (3) @(posedge clk);
    #1 empty_data_fifo = 1'b0;
    wait_done("stall", 400);

    // Bad descriptors: K+ = F+CRC_LEN, zero counts, K- too small.
    push_desc(0, 0, 2, 0, 24);
    push_err();
    wait_done("bad_kp", 100);
    push_desc(0, 0, 0, 50, 50);
    push_err();
    wait_done("bad_zero", 100);
    push_desc(0, 3, 0, 20, 0);
    push_err();
    wait_done("bad_km", 100);

    // Reset during OUT_CRC at bit 10: no stop, IDLE outputs at once.
    push_desc(0, 0, 2, 0, 40);
    wait_cond_crc(10);
    s_stops = mon_stops;
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_mid_outputs", int'(ov), int'(IDLE_OV));
    repeat (3) @(posedge clk);
    #1;
    chk("reset_mid_no_stop", mon_stops, s_stops);

    // A descriptor after that reset completes normally.
    push_desc(5, 1, 0, 33, 0);
    push_blk(0, 5, 28, 0, 0);
    wait_done("post_reset", 300);

    // Maximum count: 255 K+ blocks of 25 = 1 read + 24 crc each.
    push_desc(0, 0, 255, 0, 25);
    for (int i = 0; i < 255; i++) push_blk(1, 0, 1, 24, 0);
    wait_done("max_count", 20000);

    // Back-to-back descriptors: the second pop comes 2 cycles after the first final stop.
    stop_cyc.delete();
    rs_cyc.delete();
    push_desc(0, 0, 1, 0, 40);
    push_desc(0, 0, 1, 0, 40);
    push_blk(1, 0, 40, 0, 0);
    push_blk(1, 0, 40, 0, 0);
    wait_done("b2b", 600);
    chk("b2b_pops", rs_cyc.size(), 2);
    if (rs_cyc.size() >= 2 && stop_cyc.size() >= 1)
      chk("b2b_gap", rs_cyc[1] - stop_cyc[0], 2);

    repeat (5) @(posedge clk);
    #1;
    chk("pending_left", exp_q.size(), 0);
    chk("idle_final", int'(ov), int'(IDLE_OV));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  // Global watchdog so the bench always ends.
  initial begin
    #2000000;
    n_vec++;
    n_bad++;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
